// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control slice: ALU encodings, opcodes,
// FSM states and datapath select enums.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLT = 3'b110
  } alu_ctrl_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALU = 2'b10} result_src_e;
  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011} imm_src_e;
  typedef enum logic {OPC_R = 1'b0, OPC_I = 1'b1} op_class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the control FSM and the memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps funct3/funct7b5 and the instruction class to an ALU operation; flags
// funct3 values the core does not implement.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  op_class_e  op_class,
  output alu_ctrl_e  alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct3)
      // funct7b5 selects SUB only for register-register ops; addi ignores it
      3'b000: if (op_class == OPC_R && funct7b5) alu_ctrl = ALU_SUB;
      3'b111: alu_ctrl = ALU_AND;
      3'b110: alu_ctrl = ALU_OR;
      3'b100: alu_ctrl = ALU_XOR;
      3'b010: alu_ctrl = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Optional performance counters
// are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  multicycle_ctrl_if.master mem,
  output logic        adr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic [2:0]  alu_ctrl,
  output logic        illegal_instr
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  localparam state_e ILL_NEXT = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;

  state_e      state, state_n;
  logic        req_c, we_c, adr_c, ir_c, pc_c, reg_c, ill_c;
  alu_src_a_e  src_a_c;
  alu_src_b_e  src_b_c;
  result_src_e res_c;
  imm_src_e    imm_c;
  alu_ctrl_e   alu_c;
  alu_ctrl_e   dec_alu;
  logic        dec_legal;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op_class ((state == S_EXEC_R) ? OPC_R : OPC_I),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    we_c    = 1'b0;
    adr_c   = 1'b0;
    ir_c    = 1'b0;
    pc_c    = 1'b0;
    reg_c   = 1'b0;
    ill_c   = 1'b0;
    src_a_c = SRCA_PC;
    src_b_c = SRCB_RS2;
    res_c   = RES_ALUOUT;
    imm_c   = IMM_I;
    alu_c   = ALU_ADD;
    case (state)
      S_FETCH: begin
        req_c   = 1'b1;
        src_b_c = SRCB_FOUR;
        res_c   = RES_ALU;
        if (mem.mem_ready) begin
          ir_c    = 1'b1;
          pc_c    = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures the jump/branch target ahead of BEQ or JAL
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        imm_c   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXEC_R;
          OP_I:         state_n = S_EXEC_I;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
          default:      state_n = ILL_NEXT;
        endcase
      end
      S_MEMADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        imm_c   = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        if (mem.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        reg_c   = 1'b1;
        res_c   = RES_MEMDATA;
        state_n = S_FETCH;
      end
      S_MEMWR: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        adr_c = 1'b1;
        if (mem.mem_ready) state_n = S_FETCH;
      end
      S_EXEC_R: begin
        src_a_c = SRCA_RS1;
        alu_c   = dec_alu;
        state_n = dec_legal ? S_ALUWB : ILL_NEXT;
      end
      S_EXEC_I: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        alu_c   = dec_alu;
        state_n = dec_legal ? S_ALUWB : ILL_NEXT;
      end
      S_ALUWB: begin
        reg_c   = 1'b1;
        state_n = S_FETCH;
      end
      S_BEQ: begin
        if (funct3 == 3'b000) begin
          src_a_c = SRCA_RS1;
          alu_c   = ALU_SUB;
          pc_c    = zero;
          state_n = S_FETCH;
        end else begin
          state_n = ILL_NEXT;
        end
      end
      S_JAL: begin
        // rd gets OldPC+4 in ALUWB while PC takes the target held in ALUOut
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_FOUR;
        pc_c    = 1'b1;
        state_n = S_ALUWB;
      end
      S_TRAP: ill_c = 1'b1;
      default: state_n = S_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held, abandoning any in-flight request
  assign mem.mem_req   = req_c & ~rst;
  assign mem.mem_we    = we_c & ~rst;
  assign adr_src       = adr_c & ~rst;
  assign ir_we         = ir_c & ~rst;
  assign pc_we         = pc_c & ~rst;
  assign reg_we        = reg_c & ~rst;
  assign illegal_instr = ill_c & ~rst;
  assign alu_src_a     = rst ? 2'b00  : src_a_c;
  assign alu_src_b     = rst ? 2'b00  : src_b_c;
  assign result_src    = rst ? 2'b00  : res_c;
  assign imm_src       = rst ? 3'b000 : imm_c;
  assign alu_ctrl      = rst ? 3'b000 : alu_c;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_n == S_FETCH && state != S_FETCH && state != S_TRAP)
        instret <= instret + 32'd1;
    end
  end
`endif

endmodule
